hours24_counter: RTL and testbench
==================================

Name: hours24_counter

Overview:
- Hours stage of the digital clock; sits directly downstream of the minutes/seconds chain.
- Consumes the one-cycle carry from the minutes stage and keeps a BCD hour value 00–23.
- Drives the two hour digits in 24 h or 12 h format, with a PM flag and a day carry.
- Also owns manual hour setting: a set button with edge detect and hold-to-auto-repeat.

Parameters:
- RESET_HOUR, 0: hour loaded on reset, binary 0..23.
- HOLD_CYCLES, 8: clock cycles the set button must be held after the first increment before auto-repeat starts; must be ≥ 1.
- REPEAT_CYCLES, 4: clock cycles between auto-repeat increments; must be ≥ 1.

Ports:
- ck  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- carry_in  input  1  one-cycle pulse from the minutes stage (minute 59 rolling to 00).
- set_en  input  1  level; 1 = set mode (count frozen, button active).
- set_btn  input  1  set button level, already synchronised and debounced.
- mode12  input  1  level; 1 = 12 h display, 0 = 24 h display.
- display0  output  4  hour units, BCD.
- display1  output  4  hour tens, BCD.
- pm  output  1  1 when the internal hour is 12..23, in either mode.
- carry_to_days  output  1  one-cycle day-rollover pulse.

Behaviour:
- Clock and reset: one clock, ck. Reset rst_n is asynchronous and active-low.
- On reset:
  - hour = RESET_HOUR.
  - Set FSM goes to IDLE and its counter clears.
  - btn_q = 0.
  - carry_to_days = 0.
  - Displays show RESET_HOUR in the current mode.
- State: the hour is held as two BCD digits, tens 0..2 and units 0..9; only 00..23 is legal.
- Increment rule:
  - inc = (carry_in & ~set_en) | (rep_pulse & set_en).
  - On a rising ck with inc = 1, hour advances by one: units 9 → 0 with tens + 1, and 23 → 00.
  - Without inc, hour holds.
- Day carry:
  - carry_to_days = carry_in & ~set_en & (hour == 23), combinational, same cycle as the carry_in that wraps 23 → 00.
  - A wrap caused by setting never produces carry_to_days.
- Set mode: while set_en = 1, carry_in is ignored entirely (no increment, no carry).
- Set FSM (sub-module), with btn_q = set_btn registered one cycle:
  - IDLE: a rising edge (set_btn & ~btn_q) while set_en = 1 → rep_pulse = 1 that cycle, clear counter, go to HOLD.
  - HOLD: counter increments each cycle. When counter == HOLD_CYCLES-1 → rep_pulse, clear counter, go to REPEAT.
  - REPEAT: counter increments. When counter == REPEAT_CYCLES-1 → rep_pulse, clear counter, stay in REPEAT.
  - From any state: set_btn = 0 or set_en = 0 → IDLE, counter cleared, no pulse that cycle.
- Timing: first increment is 1 cycle after the press edge. A continuous hold of N cycles produces 1 + floor((N-1-HOLD_CYCLES)/REPEAT_CYCLES) + 1 increments, once N > HOLD_CYCLES.
- Display mapping (combinational from registered hour):
  - mode12 = 0: digits = hour.
  - mode12 = 1: 00 → 12; 01..12 → unchanged; 13..23 → hour−12, i.e. 01..11.
  - A mode12 change takes effect the same cycle and never alters the stored hour.
- Reset asserted mid-hold or mid-count: immediate return to reset values, and no pulse is emitted on release.
- A carry_in pulse that coincides with set_en going 1 is ignored.

Decomposition:
- Shared package clock_pkg holds:
  - the BCD digit type (4 bit);
  - constants HOURS_MAX_TENS = 2, HOURS_MAX_UNITS = 3, NOON = 12;
  - helper function bcd_to_12h(tens, units) returning the mapped digits.
- One sub-module, set_autorepeat:
  - contains the edge detect, the IDLE/HOLD/REPEAT FSM and the counter sized to max(HOLD_CYCLES, REPEAT_CYCLES);
  - inputs ck, rst_n, set_en, set_btn; output rep_pulse.

Test Plan:
1. Reset with RESET_HOUR = 0, then 23 carry_in pulses → hour 23, display 2/3, pm = 1. 24th pulse → hour 00, carry_to_days high in exactly that cycle.
2. mode12 = 1 while stepping hour 00, 11, 12, 13, 23 → displays 1/2 pm 0, 1/1 pm 0, 1/2 pm 1, 0/1 pm 1, 1/1 pm 1.
3. set_en = 1 at hour 22, carry_in pulsed 3 times → hour stays 22, carry_to_days stays 0. One 1-cycle set_btn press → hour 23 on the next cycle.
4. set_en = 1, HOLD_CYCLES = 8, REPEAT_CYCLES = 4, set_btn held 20 cycles from hour 05 → pulses at press+1, +9, +13, +17, final hour 09. Release → no further change.
5. Set from hour 23 with one press → hour 00 and carry_to_days = 0. Then set_en dropped with the button still held → FSM to IDLE, no increments.
6. rst_n pulsed low mid-REPEAT at hour 14 → hour returns asynchronously to RESET_HOUR, and there is no rep_pulse after release until a new rising edge of set_btn.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and helpers for the digital clock stages.
// Hours are held as two BCD digits; the 12 h display view is derived, never stored.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } hour_bcd_t;

  localparam bcd_t       HOURS_MAX_TENS  = 4'd2;
  localparam bcd_t       HOURS_MAX_UNITS = 4'd3;
  localparam logic [4:0] NOON            = 5'd12;

  typedef enum logic [1:0] {
    SA_IDLE,
    SA_HOLD,
    SA_REPEAT
  } sa_state_e;

  // 00 -> 12, 01..12 unchanged, 13..23 -> 01..11
  function automatic hour_bcd_t bcd_to_12h(input bcd_t tens, input bcd_t units);
    logic [4:0] h;
    logic [4:0] m;
    hour_bcd_t  r;
    h = (5'(tens) * 5'd10) + 5'(units);
    if (h == 5'd0)     m = NOON;
    else if (h > NOON) m = h - NOON;
    else               m = h;
    r.tens  = (m >= 5'd10) ? 4'd1 : 4'd0;
    r.units = 4'((m >= 5'd10) ? (m - 5'd10) : m);
    return r;
  endfunction

endpackage

// File: rtl/hours24_counter_if.sv
// Bus between the hours stage and its neighbours: minute carry and set controls in,
// display digits, PM flag and day carry out.
interface hours24_counter_if;
  import clock_pkg::*;

  logic carry_in;
  logic set_en;
  logic set_btn;
  logic mode12;
  bcd_t display0;
  bcd_t display1;
  logic pm;
  logic carry_to_days;

  modport master (
    output carry_in, set_en, set_btn, mode12,
    input  display0, display1, pm, carry_to_days
  );

  modport slave (
    input  carry_in, set_en, set_btn, mode12,
    output display0, display1, pm, carry_to_days
  );

endinterface

// File: rtl/set_autorepeat.sv
// Set-button edge detect with hold-to-auto-repeat: one pulse on press, one after
// HOLD_CYCLES more cycles, then one every REPEAT_CYCLES while still held.
module set_autorepeat
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic ck,
  input  logic rst_n,
  input  logic set_en,
  input  logic set_btn,
  output logic rep_pulse
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  sa_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          btn_q;
  logic          rise;

  assign rise = set_btn & ~btn_q;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= SA_IDLE;
      cnt   <= '0;
      btn_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      btn_q <= set_btn;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rep_pulse = 1'b0;
    // Releasing the button or leaving set mode aborts any sequence without a pulse.
    if (!set_en || !set_btn) begin
      state_n = SA_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        SA_IDLE: begin
          if (rise) begin
            rep_pulse = 1'b1;
            cnt_n     = '0;
            state_n   = SA_HOLD;
          end
        end
        SA_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rep_pulse = 1'b1;
            cnt_n     = '0;
            state_n   = SA_REPEAT;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        SA_REPEAT: begin
          if (cnt == REPEAT_LAST) begin
            rep_pulse = 1'b1;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = SA_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hours24_counter.sv
// Hours stage: BCD hour 00..23 advanced by the minute carry or by manual setting,
// displayed in 24 h or 12 h form with a PM flag and a day-rollover pulse.
module hours24_counter
  import clock_pkg::*;
#(
  parameter int RESET_HOUR    = 0,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic               ck,
  input  logic               rst_n,
  hours24_counter_if.slave   bus
);

  localparam bcd_t RST_TENS  = bcd_t'(RESET_HOUR / 10);
  localparam bcd_t RST_UNITS = bcd_t'(RESET_HOUR % 10);

  bcd_t      tens, units;
  hour_bcd_t h12;
  logic      rep_pulse;
  logic      inc;
  logic      at_max;

  set_autorepeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_set (
    .ck        (ck),
    .rst_n     (rst_n),
    .set_en    (bus.set_en),
    .set_btn   (bus.set_btn),
    .rep_pulse (rep_pulse)
  );

  assign at_max = (tens == HOURS_MAX_TENS) && (units == HOURS_MAX_UNITS);

  // Set mode owns the counter completely: the minute carry is dropped, not deferred.
  assign inc               = (bus.carry_in & ~bus.set_en) | (rep_pulse & bus.set_en);
  assign bus.carry_to_days = bus.carry_in & ~bus.set_en & at_max;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= RST_TENS;
      units <= RST_UNITS;
    end else if (inc) begin
      if (at_max) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

  always_comb begin
    h12 = bcd_to_12h(tens, units);
    if (bus.mode12) begin
      bus.display1 = h12.tens;
      bus.display0 = h12.units;
    end else begin
      bus.display1 = tens;
      bus.display0 = units;
    end
  end

  assign bus.pm = (tens == 4'd2) || ((tens == 4'd1) && (units >= 4'd2));

endmodule

// File: tb/tb_hours24_counter.sv
// Directed and random bench for hours24_counter against a cycle-level reference
// model built from hour arithmetic and press-duration rules.
module tb_hours24_counter;

  localparam int RST_H = 0;
  localparam int HOLD  = 8;
  localparam int REP   = 4;

  logic ck    = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  hours24_counter_if bus();

  hours24_counter #(
    .RESET_HOUR    (RST_H),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: integer hour, previous button level, and press duration.
  int m_hour;
  bit m_prev;
  bit m_active;
  int m_k;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hour   = RST_H;
    m_prev   = 1'b0;
    m_active = 1'b0;
    m_k      = 0;
  endtask

  task automatic check_disp(input string tag);
    int h;
    h = m_hour;
    if (bus.mode12) h = (m_hour == 0) ? 12 : ((m_hour > 12) ? m_hour - 12 : m_hour);
    chk({tag, "_d1"}, {4'h0, bus.display1}, 8'(h / 10));
    chk({tag, "_d0"}, {4'h0, bus.display0}, 8'(h % 10));
    chk({tag, "_pm"}, {7'h0, bus.pm}, 8'(m_hour >= 12));
  endtask

  task automatic check_hour(input string tag, input int h);
    chk({tag, "_hour"}, 8'(bus.display1 * 10 + bus.display0), 8'(h));
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit c, input bit s, input bit b, input bit m12);
    bit pulse;
    bus.carry_in = c;
    bus.set_en   = s;
    bus.set_btn  = b;
    bus.mode12   = m12;
    #1;
    chk("cday", {7'h0, bus.carry_to_days}, 8'(c && !s && m_hour == 23));
    check_disp("pre");
    @(posedge ck);
    pulse = 1'b0;
    if (s && b) begin
      if (!m_active) begin
        if (!m_prev) begin
          m_active = 1'b1;
          m_k      = 0;
          pulse    = 1'b1;
        end
      end else begin
        m_k++;
        if (m_k == HOLD || (m_k > HOLD && (m_k - HOLD) % REP == 0)) pulse = 1'b1;
      end
    end else begin
      m_active = 1'b0;
    end
    if ((c && !s) || (pulse && s)) m_hour = (m_hour + 1) % 24;
    m_prev = b;
    @(negedge ck);
    check_disp("post");
  endtask

  task automatic to_hour(input int target, input bit m12);
    for (int i = 0; i < 24; i++)
      if (m_hour != target) step(1'b1, 1'b0, 1'b0, m12);
    step(1'b0, 1'b0, 1'b0, m12);
  endtask

  // Reset asserted between edges; outputs must follow without a clock edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    bus.set_btn = 1'b0;
    check_disp("async_rst");
    @(negedge ck);
    rst_n = 1'b1;
  endtask

  initial begin
    bit c, s, b, m;
    bus.carry_in = 1'b0;
    bus.set_en   = 1'b0;
    bus.set_btn  = 1'b0;
    bus.mode12   = 1'b0;
    model_reset();
    @(negedge ck);
    @(negedge ck);
    chk("rst_cday", {7'h0, bus.carry_to_days}, 8'h00);
    check_disp("rst");
    rst_n = 1'b1;

    // 23 minute carries reach 23, the 24th wraps with a day carry.
    for (int i = 0; i < 23; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_hour("t1_23", 23);
    chk("t1_pm", {7'h0, bus.pm}, 8'h01);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_hour("t1_wrap", 0);

    // 12 h display across the interesting hours.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    to_hour(11, 1'b1);
    to_hour(12, 1'b1);
    to_hour(13, 1'b1);
    to_hour(23, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Set mode ignores carries; a single press advances once.
    to_hour(22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check_hour("t3_frozen", 22);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_hour("t3_press", 23);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Hold for 20 cycles from 05: four increments.
    to_hour(5, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check_hour("t4_hold", 9);

    // Set wrap 23 -> 00 without day carry, then leave set mode with the button held.
    to_hour(23, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    check_hour("t5_wrap", 0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    check_hour("t5_noinc", 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of auto-repeat.
    to_hour(14, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    pulse_reset();
    check_hour("t6_rst", RST_H);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check_hour("t6_quiet", RST_H);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    c = 1'b0; s = 1'b0; b = 1'b0; m = 1'b0;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom % 3) == 0;
      if (($urandom % 20) == 0) s = ~s;
      if (($urandom % 8) == 0)  b = ~b;
      if (($urandom % 16) == 0) m = ~m;
      if (($urandom % 250) == 0) begin
        pulse_reset();
        b = 1'b0;
      end
      step(c, s, b, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
